// File: rtl/ps2_note_pkg.sv
// Shared constants, parser state type and status-byte helper for the PS/2 note tracker.
package ps2_note_pkg;

   localparam int CODE_W = 9;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ECHO   = 8'hEE;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } parser_state_t;

   // Keyboard housekeeping bytes that never take part in a make/break sequence.
   function automatic logic is_status(input logic [7:0] b);
      return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) || (b == SC_ECHO);
   endfunction

endpackage

// File: rtl/ps2_note_tracker_if.sv
// Byte-input and note-channel output bundle between PS/2 receiver, tracker and mixer.
interface ps2_note_tracker_if #(
   parameter int NUM_CH   = 4,
   parameter int CH_IDX_W = 3
) ();
   logic [7:0]          ps2_byte;
   logic                ps2_byte_en;
   logic                panic;
   logic [9*NUM_CH-1:0] ch_code;
   logic [NUM_CH-1:0]   ch_active;
   logic                note_on;
   logic                note_off;
   logic [CH_IDX_W-1:0] evt_ch;
   logic [7:0]          last_byte;

   modport master (
      output ps2_byte, ps2_byte_en, panic,
      input  ch_code, ch_active, note_on, note_off, evt_ch, last_byte
   );

   modport slave (
      input  ps2_byte, ps2_byte_en, panic,
      output ch_code, ch_active, note_on, note_off, evt_ch, last_byte
   );
endinterface

// File: rtl/ps2_scan_parser.sv
// Set-2 make/break prefix decoder with an idle timeout that abandons half-received prefixes.
module ps2_scan_parser
   import ps2_note_pkg::*;
#(
   parameter int TIMEOUT = 500000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        ps2_byte,
   input  logic              ps2_byte_en,
   input  logic              panic,
   output logic              evt_make,
   output logic              evt_break,
   output logic [CODE_W-1:0] evt_code
);

   localparam int             TMO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

   parser_state_t    state_q, state_d;
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit;

   assign tmo_hit = (state_q != ST_IDLE) && !ps2_byte_en && (tmo_q == TMO_MAX);

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      state_d   = state_q;
      evt_make  = 1'b0;
      evt_break = 1'b0;
      evt_code  = {1'b0, ps2_byte};
      if (panic) begin
         state_d = ST_IDLE;
      end else if (ps2_byte_en && !is_status(ps2_byte)) begin
         unique case (state_q)
            ST_IDLE: begin
               if (ps2_byte == SC_EXT)      state_d = ST_EXT;
               else if (ps2_byte == SC_BRK) state_d = ST_BRK;
               else                         evt_make = 1'b1;
            end
            ST_EXT: begin
               if (ps2_byte == SC_BRK)      state_d = ST_EXT_BRK;
               else if (ps2_byte != SC_EXT) begin
                  evt_make = 1'b1;
                  evt_code = {1'b1, ps2_byte};
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (ps2_byte != SC_BRK && ps2_byte != SC_EXT) begin
                  evt_break = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if (ps2_byte != SC_BRK && ps2_byte != SC_EXT) begin
                  evt_break = 1'b1;
                  evt_code  = {1'b1, ps2_byte};
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_d = ST_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         if (panic || ps2_byte_en || state_q == ST_IDLE || tmo_hit) tmo_q <= '0;
         else                                                     tmo_q <= tmo_q + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_note_tracker.sv
// Polyphonic key tracker: maps decoded make/break events onto NUM_CH note channels.
module ps2_note_tracker
   import ps2_note_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int TIMEOUT  = 500000,
   parameter int CH_IDX_W = 3
) (
   input  logic               CLOCK_50,
   input  logic               KEY0,
   ps2_note_tracker_if.slave  bus
);

   logic                evt_make, evt_break;
   logic [CODE_W-1:0]   evt_code;

   logic [CODE_W-1:0]   code_q [NUM_CH];
   logic [NUM_CH-1:0]   act_q;
   logic [CH_IDX_W-1:0] steal_ptr_q;
   logic [CH_IDX_W-1:0] evt_ch_q;
   logic                note_on_q, note_off_q;
   logic [7:0]          last_byte_q;

   logic                match_hit, free_hit;
   logic [CH_IDX_W-1:0] match_idx, free_idx, alloc_idx;

   ps2_scan_parser #(.TIMEOUT(TIMEOUT)) u_parser (
      .clk         (CLOCK_50),
      .rst_n       (KEY0),
      .ps2_byte    (bus.ps2_byte),
      .ps2_byte_en (bus.ps2_byte_en),
      .panic       (bus.panic),
      .evt_make    (evt_make),
      .evt_break   (evt_break),
      .evt_code    (evt_code)
   );

   // Scanning downward makes the lowest matching/free index win.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (act_q[i] && code_q[i] == evt_code) begin
            match_hit = 1'b1;
            match_idx = CH_IDX_W'(i);
         end
         if (!act_q[i]) begin
            free_hit = 1'b1;
            free_idx = CH_IDX_W'(i);
         end
      end
      alloc_idx = free_hit ? free_idx : steal_ptr_q;
   end

   // NOTE: the channel array is a handful of flops, so it is reset like any other register.
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         for (int i = 0; i < NUM_CH; i++) code_q[i] <= '0;
         act_q       <= '0;
         steal_ptr_q <= '0;
         evt_ch_q    <= '0;
         note_on_q   <= 1'b0;
         note_off_q  <= 1'b0;
         last_byte_q <= '0;
      end else begin
         note_on_q  <= 1'b0;
         note_off_q <= 1'b0;
         if (bus.ps2_byte_en) last_byte_q <= bus.ps2_byte;

         if (bus.panic) begin
            act_q <= '0;
         end else if (evt_make && !match_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (alloc_idx == CH_IDX_W'(i)) begin
                  act_q[i]  <= 1'b1;
                  code_q[i] <= evt_code;
               end
            end
            // A stolen key is silently overwritten; the ring pointer moves on.
            if (!free_hit) begin
               if (steal_ptr_q == CH_IDX_W'(NUM_CH - 1)) steal_ptr_q <= '0;
               else                                      steal_ptr_q <= steal_ptr_q + 1'b1;
            end
            note_on_q <= 1'b1;
            evt_ch_q  <= alloc_idx;
         end else if (evt_break && match_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (match_idx == CH_IDX_W'(i)) act_q[i] <= 1'b0;
            end
            note_off_q <= 1'b1;
            evt_ch_q   <= match_idx;
         end
      end
   end

   always_comb begin
      bus.ch_code = '0;
      for (int i = 0; i < NUM_CH; i++) bus.ch_code[CODE_W*i +: CODE_W] = code_q[i];
   end

   assign bus.ch_active = act_q;
   assign bus.note_on   = note_on_q;
   assign bus.note_off  = note_off_q;
   assign bus.evt_ch    = evt_ch_q;
   assign bus.last_byte = last_byte_q;

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Directed, table-driven bench for ps2_note_tracker with NUM_CH=4 and a short timeout.
module tb_ps2_note_tracker;

   localparam int NUM_CH   = 4;
   localparam int TIMEOUT  = 16;
   localparam int CH_IDX_W = 3;

   typedef struct {
      logic [7:0]  b;
      logic        p;
      logic [3:0]  act;
      logic        on;
      logic        off;
      logic [2:0]  ch;
      logic [35:0] codes;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs[$];

   ps2_note_tracker_if #(.NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W)) bus ();

   ps2_note_tracker #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT), .CH_IDX_W(CH_IDX_W)) u_dut (
      .CLOCK_50 (clk),
      .KEY0     (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic p);
      @(negedge clk);
      bus.ps2_byte    = b;
      bus.ps2_byte_en = 1'b1;
      bus.panic       = p;
      @(posedge clk);
      #1;
      bus.ps2_byte_en = 1'b0;
      bus.panic       = 1'b0;
   endtask

   task automatic add(input logic [7:0] b, input logic p, input logic [3:0] act,
                      input logic on, input logic off, input logic [2:0] ch,
                      input logic [8:0] c3, input logic [8:0] c2,
                      input logic [8:0] c1, input logic [8:0] c0);
      vec_t v;
      v.b = b; v.p = p; v.act = act; v.on = on; v.off = off; v.ch = ch;
      v.codes = {c3, c2, c1, c0};
      vecs.push_back(v);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.ps2_byte = '0;
      bus.ps2_byte_en = 1'b0;
      bus.panic = 1'b0;

      //   byte  pn act    on off ch  c3      c2      c1      c0
      add(8'h1C, 0, 4'h1, 1, 0, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'hF0, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'h1C, 0, 4'h0, 0, 1, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'hE0, 0, 4'h0, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'h75, 0, 4'h1, 1, 0, 0, 9'h000, 9'h000, 9'h000, 9'h175);
      add(8'hF0, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h175);
      add(8'h75, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h175);
      add(8'hE0, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h175);
      add(8'hF0, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h175);
      add(8'h75, 0, 4'h0, 0, 1, 0, 9'h000, 9'h000, 9'h000, 9'h175);
      add(8'h1C, 0, 4'h1, 1, 0, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'h1C, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'h1C, 0, 4'h1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h01C);
      add(8'h1B, 0, 4'h3, 1, 0, 1, 9'h000, 9'h000, 9'h01B, 9'h01C);
      add(8'h23, 0, 4'h7, 1, 0, 2, 9'h000, 9'h023, 9'h01B, 9'h01C);
      add(8'h2B, 0, 4'hF, 1, 0, 3, 9'h02B, 9'h023, 9'h01B, 9'h01C);
      add(8'h34, 0, 4'hF, 1, 0, 0, 9'h02B, 9'h023, 9'h01B, 9'h034);
      add(8'hF0, 0, 4'hF, 0, 0, 0, 9'h02B, 9'h023, 9'h01B, 9'h034);
      add(8'h1C, 0, 4'hF, 0, 0, 0, 9'h02B, 9'h023, 9'h01B, 9'h034);
      add(8'hF0, 0, 4'hF, 0, 0, 0, 9'h02B, 9'h023, 9'h01B, 9'h034);
      add(8'h34, 0, 4'hE, 0, 1, 0, 9'h02B, 9'h023, 9'h01B, 9'h034);
      add(8'h1C, 0, 4'hF, 1, 0, 0, 9'h02B, 9'h023, 9'h01B, 9'h01C);
      add(8'h35, 0, 4'hF, 1, 0, 1, 9'h02B, 9'h023, 9'h035, 9'h01C);
      add(8'hE0, 0, 4'hF, 0, 0, 1, 9'h02B, 9'h023, 9'h035, 9'h01C);
      add(8'hAA, 0, 4'hF, 0, 0, 1, 9'h02B, 9'h023, 9'h035, 9'h01C);
      add(8'h1C, 0, 4'hF, 1, 0, 2, 9'h02B, 9'h11C, 9'h035, 9'h01C);
      add(8'h1C, 1, 4'h0, 0, 0, 2, 9'h02B, 9'h11C, 9'h035, 9'h01C);
      add(8'hE0, 0, 4'h0, 0, 0, 2, 9'h02B, 9'h11C, 9'h035, 9'h01C);
      add(8'h75, 1, 4'h0, 0, 0, 2, 9'h02B, 9'h11C, 9'h035, 9'h01C);
      add(8'h75, 0, 4'h1, 1, 0, 0, 9'h02B, 9'h11C, 9'h035, 9'h075);
      add(8'hFA, 0, 4'h1, 0, 0, 0, 9'h02B, 9'h11C, 9'h035, 9'h075);

      repeat (3) @(posedge clk);
      #1;
      check("reset ch_active", 64'(bus.ch_active), 64'h0);
      check("reset ch_code",   64'(bus.ch_code),   64'h0);
      check("reset pulses",    64'({bus.note_on, bus.note_off}), 64'h0);
      check("reset evt_ch",    64'(bus.evt_ch),    64'h0);
      check("reset last_byte", 64'(bus.last_byte), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         send_byte(vecs[i].b, vecs[i].p);
         check($sformatf("v%0d ch_active", i), 64'(bus.ch_active), 64'(vecs[i].act));
         check($sformatf("v%0d note_on", i),   64'(bus.note_on),   64'(vecs[i].on));
         check($sformatf("v%0d note_off", i),  64'(bus.note_off),  64'(vecs[i].off));
         check($sformatf("v%0d evt_ch", i),    64'(bus.evt_ch),    64'(vecs[i].ch));
         check($sformatf("v%0d ch_code", i),   64'(bus.ch_code),   64'(vecs[i].codes));
         check($sformatf("v%0d last_byte", i), 64'(bus.last_byte), 64'(vecs[i].b));
      end

      // Expired E0 prefix: next byte decodes as a plain make into lowest free ch1.
      send_byte(8'hE0, 1'b0);
      repeat (TIMEOUT + 2) @(posedge clk);
      send_byte(8'h1C, 1'b0);
      check("timeout make on", 64'(bus.note_on), 64'h1);
      check("timeout evt_ch",  64'(bus.evt_ch),  64'h1);
      check("timeout code",    64'(bus.ch_code[17:9]), 64'h01C);
      check("timeout active",  64'(bus.ch_active), 64'h3);

      // Prefix still alive just before the timeout: extended make into ch2.
      send_byte(8'hE0, 1'b0);
      repeat (TIMEOUT - 4) @(posedge clk);
      send_byte(8'h1C, 1'b0);
      check("pre-timeout on",     64'(bus.note_on), 64'h1);
      check("pre-timeout evt_ch", 64'(bus.evt_ch),  64'h2);
      check("pre-timeout code",   64'(bus.ch_code[26:18]), 64'h11C);
      check("pre-timeout active", 64'(bus.ch_active), 64'h7);
      @(posedge clk);
      #1;
      check("note_on width", 64'(bus.note_on), 64'h0);

      // Reset after a break prefix: the following byte must be a make.
      send_byte(8'hF0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #3;
      check("mid reset active", 64'(bus.ch_active), 64'h0);
      check("mid reset code",   64'(bus.ch_code),   64'h0);
      rst_n = 1'b1;
      send_byte(8'h1C, 1'b0);
      check("post reset on",     64'(bus.note_on),  64'h1);
      check("post reset off",    64'(bus.note_off), 64'h0);
      check("post reset active", 64'(bus.ch_active), 64'h1);
      check("post reset code",   64'(bus.ch_code),  64'h01C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
